// File: rtl/uart_tx_fifo.sv
// Byte FIFO that launches one byte at a time into uart_tx and waits for its done.
module uart_tx_fifo #(
  parameter int unsigned DEPTH_LOG2 = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_wr_en,
  input  logic [7:0]            i_wr_byte,
  output logic                  o_full,
  output logic                  o_empty,
  output logic [DEPTH_LOG2:0]   o_count,
  output logic                  o_overflow,
  output logic                  o_tx_byte_rdy,
  output logic [7:0]            o_tx_byte,
  input  logic                  i_tx_active,
  input  logic                  i_tx_done,
  output logic                  o_busy
);

  localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   FULL_CNT = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0]   CNT_ONE  = (DEPTH_LOG2 + 1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);

  typedef enum logic {
    ST_IDLE,
    ST_WAIT
  } state_t;

  state_t                state_q;
  state_t                state_d;
  logic [7:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DEPTH_LOG2:0]   count;
  logic                  pop;
  logic                  wr_ok;

  assign o_full  = (count == FULL_CNT);
  assign o_empty = (count == '0);
  assign o_count = count;
  assign o_busy  = (state_q != ST_IDLE) || !o_empty;
  assign wr_ok   = i_wr_en && !o_full;

  // Launch decision and WAIT->IDLE on done; a done seen in IDLE is ignored.
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!o_empty && !i_tx_active) begin
          pop     = 1'b1;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (i_tx_done) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Storage array; contents are not reset, pointers define validity.
  always_ff @(posedge i_clk) begin
    if (wr_ok) begin
      mem[wr_ptr] <= i_wr_byte;
    end
  end

  // Pointers, occupancy, launch strobe and state register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q       <= ST_IDLE;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      o_overflow    <= 1'b0;
      o_tx_byte_rdy <= 1'b0;
      o_tx_byte     <= '0;
    end else begin
      state_q       <= state_d;
      o_overflow    <= i_wr_en && o_full;
      o_tx_byte_rdy <= pop;
      if (pop) begin
        o_tx_byte <= mem[rd_ptr];
        rd_ptr    <= rd_ptr + PTR_ONE;
      end
      if (wr_ok) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      case ({wr_ok, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

endmodule
